jbi_sctrdq_arb: RTL and testbench

- JBus-clock-domain arbiter/sequencer for the four SCTAG return data queues (one per SCTAG out-queue block).
- Selects among queues holding complete transactions using round-robin.
- Drains one transaction at a time: 1 beat for a 16-byte read, 4 beats for a 64-byte read, each beat 128 bits.
- Issues per-queue dequeue and transaction-count decrement pulses, and presents a valid/ready beat stream to the JBus return-data issue logic.

---
 rtl/jbi_sctrdq_arb_if.sv | 42 ++++
 rtl/jbi_sctrdq_arb.sv | 107 ++++++++++
 tb/tb_jbi_sctrdq_arb.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jbi_sctrdq_arb_if.sv
// Bundle of SCTAG return-data queue head signals and the JBus return beat stream.
// The master modport is the arbiter side and the slave modport is the queue/issue side.
interface jbi_sctrdq_arb_if #(
  parameter int NUM_Q  = 4,
  parameter int CNT_W  = 4,
  parameter int DATA_W = 128
);
  logic [NUM_Q*CNT_W-1:0]    sctrdq_trans_count;
  logic [NUM_Q-1:0]          sctrdq_data1_4;
  logic [NUM_Q-1:0]          sctrdq_install_state;
  logic [NUM_Q-1:0]          sctrdq_unmapped_error;
  logic [NUM_Q*6-1:0]        sctrdq_jid;
  logic [NUM_Q*DATA_W-1:0]   sctrdq_data;
  logic [NUM_Q-1:0]          sctrdq_ue_err;
  logic [NUM_Q-1:0]          sctrdq_dequeue;
  logic [NUM_Q-1:0]          sctrdq_dec_count;

  logic                      rdq_rdy;
  logic                      rdq_vld;
  logic [DATA_W-1:0]         rdq_data;
  logic [5:0]                rdq_jid;
  logic                      rdq_install_state;
  logic                      rdq_unmapped_error;
  logic                      rdq_ue_err;
  logic                      rdq_first;
  logic                      rdq_last;
  logic [$clog2(NUM_Q)-1:0]  rdq_src;

  modport master (
    input  sctrdq_trans_count, sctrdq_data1_4, sctrdq_install_state,
           sctrdq_unmapped_error, sctrdq_jid, sctrdq_data, sctrdq_ue_err, rdq_rdy,
    output sctrdq_dequeue, sctrdq_dec_count, rdq_vld, rdq_data, rdq_jid,
           rdq_install_state, rdq_unmapped_error, rdq_ue_err, rdq_first, rdq_last, rdq_src
  );

  modport slave (
    output sctrdq_trans_count, sctrdq_data1_4, sctrdq_install_state,
           sctrdq_unmapped_error, sctrdq_jid, sctrdq_data, sctrdq_ue_err, rdq_rdy,
    input  sctrdq_dequeue, sctrdq_dec_count, rdq_vld, rdq_data, rdq_jid,
           rdq_install_state, rdq_unmapped_error, rdq_ue_err, rdq_first, rdq_last, rdq_src
  );
endinterface

// File: rtl/jbi_sctrdq_arb.sv
// Round-robin arbiter draining one SCTAG return-data transaction at a time
// (1 or 4 beats) onto the JBus return beat stream.
module jbi_sctrdq_arb #(
  parameter int NUM_Q  = 4,
  parameter int CNT_W  = 4,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              arst_l,
  input  logic              rdq_en,
  jbi_sctrdq_arb_if.master  bus
);

  localparam int IDX_W = $clog2(NUM_Q);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [1:0]       beat_cnt;
  logic [1:0]       beat_last;

  logic [NUM_Q-1:0] req;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic             xfer;
  logic             accept;
  logic             last;
  logic [NUM_Q-1:0] grant_oh;

  always_comb begin
    req = '0;
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      req[q] = |bus.sctrdq_trans_count[q*CNT_W +: CNT_W];
    end
  end

  // First requester at or after rr_ptr, wrapping past the top queue.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      idx = IDX_W'(rr_ptr + i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      beat_cnt  <= '0;
      beat_last <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rdq_en && found) begin
            grant     <= pick;
            beat_last <= bus.sctrdq_data1_4[pick] ? 2'd0 : 2'd3;
            beat_cnt  <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (last) begin
              rr_ptr <= grant + IDX_W'(1);
              state  <= GAP;
            end
          end
        end
        // Lets the queue's registered count absorb the decrement before re-arbitrating.
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign xfer     = (state == XFER);
  assign accept   = xfer & bus.rdq_rdy;
  assign last     = (beat_cnt == beat_last);
  assign grant_oh = NUM_Q'(1) << grant;

  assign bus.sctrdq_dequeue   = accept ? grant_oh : '0;
  assign bus.sctrdq_dec_count = (accept && last) ? grant_oh : '0;

  assign bus.rdq_vld            = xfer;
  assign bus.rdq_data           = bus.sctrdq_data[grant*DATA_W +: DATA_W];
  assign bus.rdq_jid            = bus.sctrdq_jid[grant*6 +: 6];
  assign bus.rdq_install_state  = bus.sctrdq_install_state[grant];
  assign bus.rdq_unmapped_error = bus.sctrdq_unmapped_error[grant];
  assign bus.rdq_ue_err         = bus.sctrdq_ue_err[grant];
  assign bus.rdq_first          = (beat_cnt == 2'd0);
  assign bus.rdq_last           = last;
  assign bus.rdq_src            = grant;

endmodule

// File: tb/tb_jbi_sctrdq_arb.sv
// Bench for jbi_sctrdq_arb: behavioural queue model feeding the arbiter, with a
// scoreboard of expected beats checked as the arbiter accepts them.
module tb_jbi_sctrdq_arb;

  logic clk = 1'b0;
  logic arst_l = 1'b0;
  logic rdq_en = 1'b0;
  logic rdy = 1'b0;
  logic [3:0] d14 = 4'b0000;

  jbi_sctrdq_arb_if #(.NUM_Q(4), .CNT_W(4), .DATA_W(128)) bus ();

  jbi_sctrdq_arb #(.NUM_Q(4), .CNT_W(4), .DATA_W(128)) dut (
    .clk    (clk),
    .arst_l (arst_l),
    .rdq_en (rdq_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_data(int q, int t, int b);
    logic [31:0] w;
    w = {8'(q), 8'(t), 8'(b), 8'h5A ^ 8'(q * 3 + t)};
    return {w, ~w, w ^ 32'h1234_5678, {w[15:0], w[31:16]}};
  endfunction
  function automatic logic [5:0] mk_jid(int q, int t);
    return {2'(q), 4'(t)};
  endfunction
  function automatic logic mk_inst(int q, int t);
    return 1'(q ^ t);
  endfunction
  function automatic logic mk_unm(int q, int t);
    return 1'((q + t) >> 1);
  endfunction
  function automatic logic mk_ue(int q, int t, int b);
    return ((b + t + q) % 3) == 0;
  endfunction

  // Queue model: per-queue transaction count, head transaction index, head beat index.
  int qcnt[4], qtxn[4], qbeat[4];
  int add_req[4];

  always @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      for (int q = 0; q < 4; q++) begin
        qcnt[q] <= 0; qtxn[q] <= 0; qbeat[q] <= 0;
      end
    end else begin
      for (int q = 0; q < 4; q++) begin
        if (bus.sctrdq_dec_count[q]) begin
          qcnt[q]  <= qcnt[q] + add_req[q] - 1;
          qtxn[q]  <= qtxn[q] + 1;
          qbeat[q] <= 0;
        end else begin
          qcnt[q] <= qcnt[q] + add_req[q];
          if (bus.sctrdq_dequeue[q]) qbeat[q] <= qbeat[q] + 1;
        end
      end
    end
  end

  always_comb begin
    bus.sctrdq_trans_count    = '0;
    bus.sctrdq_data           = '0;
    bus.sctrdq_jid            = '0;
    bus.sctrdq_install_state  = '0;
    bus.sctrdq_unmapped_error = '0;
    bus.sctrdq_ue_err         = '0;
    for (int q = 0; q < 4; q++) begin
      bus.sctrdq_trans_count[q*4 +: 4]  = 4'(qcnt[q] > 15 ? 15 : qcnt[q]);
      bus.sctrdq_data[q*128 +: 128]     = mk_data(q, qtxn[q], qbeat[q]);
      bus.sctrdq_jid[q*6 +: 6]          = mk_jid(q, qtxn[q]);
      bus.sctrdq_install_state[q]       = mk_inst(q, qtxn[q]);
      bus.sctrdq_unmapped_error[q]      = mk_unm(q, qtxn[q]);
      bus.sctrdq_ue_err[q]              = mk_ue(q, qtxn[q], qbeat[q]);
    end
  end

  assign bus.sctrdq_data1_4 = d14;
  assign bus.rdq_rdy        = rdy;

  typedef struct { int q; int t; int b; int nb; } beat_t;
  beat_t sb[$];
  int exp_txn[4];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_deq = 0;
  int n_dec = 0;
  int end_cyc = 0;
  int gap_obs = 0;
  logic vld_seen;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_txn(int q, int nb);
    for (int b = 0; b < nb; b++) sb.push_back('{q, exp_txn[q], b, nb});
    exp_txn[q]++;
  endtask

  task automatic check_beat();
    beat_t e;
    chk("beat_expected", 128'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("src", bus.rdq_src, e.q);
      chk("data", bus.rdq_data, mk_data(e.q, e.t, e.b));
      chk("jid", bus.rdq_jid, mk_jid(e.q, e.t));
      chk("install", bus.rdq_install_state, mk_inst(e.q, e.t));
      chk("unmapped", bus.rdq_unmapped_error, mk_unm(e.q, e.t));
      chk("ue", bus.rdq_ue_err, mk_ue(e.q, e.t, e.b));
      chk("first", bus.rdq_first, e.b == 0);
      chk("last", bus.rdq_last, e.b == e.nb - 1);
      chk("dequeue", bus.sctrdq_dequeue, 4'b0001 << e.q);
      chk("dec_count", bus.sctrdq_dec_count, (e.b == e.nb - 1) ? (4'b0001 << e.q) : 4'b0000);
      if (e.b == 0) gap_obs = cyc - end_cyc;
      if (e.b == e.nb - 1) end_cyc = cyc;
    end
  endtask

  // Checks at the falling edge, then inputs may change just after the rising edge.
  task automatic tick();
    @(negedge clk);
    vld_seen = bus.rdq_vld;
    if (arst_l) begin
      n_deq += $countones(bus.sctrdq_dequeue);
      n_dec += $countones(bus.sctrdq_dec_count);
      if (bus.rdq_vld && bus.rdq_rdy) check_beat();
      else chk("no_pulse", {bus.sctrdq_dequeue, bus.sctrdq_dec_count}, 0);
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int q = 0; q < 4; q++) add_req[q] = 0;
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_done", sb.size(), 0);
    repeat (4) tick();
  endtask

  task automatic wait_vld(int budget);
    int k;
    k = 0;
    while (!bus.rdq_vld && k < budget) begin
      tick();
      k++;
    end
    chk("vld_rise", bus.rdq_vld, 1);
  endtask

  typedef struct { logic [15:0] add; logic [3:0] d14; int n; logic [15:0] order; } vec_t;
  vec_t vec[6];

  initial begin
    int d0, e0;
    logic [4:0] pat;

    // add counts per queue (q at [4q+3:4q]), sizes, transaction count, grant order (2 bits each, LSB first)
    vec[0] = '{16'h1000, 4'b1000, 1, 16'h0003};
    vec[1] = '{16'h2222, 4'b1111, 8, 16'hE4E4};
    vec[2] = '{16'h0100, 4'b0100, 1, 16'h0002};
    vec[3] = '{16'h1010, 4'b1000, 2, 16'h0007};
    vec[4] = '{16'h0101, 4'b0000, 2, 16'h0002};
    vec[5] = '{16'h0011, 4'b0011, 2, 16'h0001};

    for (int q = 0; q < 4; q++) begin add_req[q] = 0; exp_txn[q] = 0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_vld", bus.rdq_vld, 0);
    chk("reset_pulses", {bus.sctrdq_dequeue, bus.sctrdq_dec_count}, 0);
    @(posedge clk);
    #1;
    arst_l = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      d14 = vec[i].d14;
      rdq_en = 1'b1;
      rdy = 1'b1;
      for (int q = 0; q < 4; q++) add_req[q] = int'(vec[i].add[q*4 +: 4]);
      for (int j = 0; j < vec[i].n; j++) begin
        int q;
        q = int'(vec[i].order[2*j +: 2]);
        push_txn(q, d14[q] ? 1 : 4);
      end
      d0 = n_dec;
      drain(200);
      chk("dec_total", n_dec - d0, vec[i].n);
    end

    // 64-byte read with back-pressure; size flip mid-transfer must be ignored
    d14 = 4'b0000;
    rdy = 1'b0;
    add_req[0] = 1;
    push_txn(0, 4);
    wait_vld(20);
    d0 = n_deq; e0 = n_dec;
    pat = 5'b11101;
    for (int j = 0; j < 5; j++) begin
      rdy = pat[j];
      if (j == 1) d14[0] = 1'b1;
      tick();
    end
    rdy = 1'b1;
    repeat (3) tick();
    chk("bp_deq_count", n_deq - d0, 4);
    chk("bp_dec_count", n_dec - e0, 1);
    chk("bp_sb_empty", sb.size(), 0);

    // Enable gating, one-cycle start latency, and disable during transfer
    rdq_en = 1'b0;
    d14 = 4'b0010;
    add_req[1] = 3;
    repeat (5) begin
      tick();
      chk("en_blocks", vld_seen, 0);
    end
    push_txn(1, 1);
    rdq_en = 1'b1;
    d0 = n_dec;
    tick();
    chk("en_lat0", vld_seen, 0);
    rdq_en = 1'b0;
    tick();
    chk("en_lat1", vld_seen, 1);
    repeat (8) tick();
    chk("en_off_dec", n_dec - d0, 1);
    chk("en_off_sb", sb.size(), 0);
    rdq_en = 1'b1;
    push_txn(1, 1);
    push_txn(1, 1);
    drain(50);

    // Reset during beat 2 of a 64-byte transfer, then arbitration restarts at queue 0
    d14 = 4'b0000;
    add_req[0] = 1;
    push_txn(0, 4);
    d0 = n_deq;
    begin
      int k;
      k = 0;
      while ((n_deq - d0) < 2 && k < 20) begin tick(); k++; end
    end
    chk("rst_prebeats", n_deq - d0, 2);
    arst_l = 1'b0;
    #1;
    chk("rst_vld", bus.rdq_vld, 0);
    chk("rst_deq", bus.sctrdq_dequeue, 0);
    chk("rst_dec", bus.sctrdq_dec_count, 0);
    sb.delete();
    for (int q = 0; q < 4; q++) exp_txn[q] = 0;
    repeat (2) tick();
    arst_l = 1'b1;
    d14 = 4'b1001;
    add_req[0] = 1;
    add_req[3] = 1;
    push_txn(0, 1);
    push_txn(3, 1);
    drain(50);

    // New request arriving during a transfer is served after exactly a 2-cycle bubble
    d14 = 4'b0000;
    add_req[3] = 1;
    push_txn(3, 4);
    wait_vld(20);
    d14[0] = 1'b1;
    add_req[0] = 1;
    push_txn(0, 1);
    drain(50);
    chk("bubble", gap_obs, 3);

    // Full-scale count is a normal request
    d14 = 4'b0100;
    add_req[2] = 15;
    push_txn(2, 1);
    d0 = n_dec;
    begin
      int k;
      k = 0;
      while (n_dec == d0 && k < 20) begin tick(); k++; end
    end
    rdq_en = 1'b0;
    repeat (6) tick();
    chk("cnt15_dec", n_dec - d0, 1);
    chk("cnt15_left", qcnt[2], 14);
    chk("cnt15_sb", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
